// File: rtl/fp_divider.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit
// per cycle, truncated result, start/done handshake.
module fp_divider #(
  parameter int unsigned QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Quotient
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned REM_W  = MANT_W + 1;
  localparam int unsigned CNT_W  = 5;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DIV  = 2'd2,
    ST_PACK = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic [MANT_W-1:0]         ma_q, ma_d, mb_q, mb_d;
  logic signed [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
  logic                      spec_q, spec_d;
  logic [31:0]               spec_res_q, spec_res_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [QBITS-1:0]          quo_q, quo_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [31:0]               quotient_q, quotient_d;

  logic                      a_zero, b_zero, a_nanf, b_nanf, sign_in;
  logic                      rem_ge;
  logic [MANT_W-1:0]         rem_next;
  logic signed [EXP_W-1:0]   e_pack;
  logic [22:0]               frac_pack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quotient_q <= '0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quotient_q <= quotient_d;
    end
  end

  // Operand classification on the raw inputs, used only when a start is accepted
  always_comb begin
    a_zero  = (A[30:0] == 31'h0);
    b_zero  = (B[30:0] == 31'h0);
    a_nanf  = (A[30:23] == 8'hFF);
    b_nanf  = (B[30:23] == 8'hFF);
    sign_in = A[31] ^ B[31];
  end

  // Restoring step and result packing datapath
  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mb_q});
    rem_next = rem_ge ? MANT_W'(rem_q - {1'b0, mb_q}) : rem_q[MANT_W-1:0];
    e_pack   = ea_q - eb_q + 10'sd127;
    if (quo_q[QBITS-1]) begin
      frac_pack = quo_q[QBITS-2:2];
    end else begin
      frac_pack = quo_q[QBITS-3:1];
      e_pack    = e_pack - 10'sd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quotient_d = quotient_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d = sign_in;
          ma_d   = {(A[30:23] != 8'h00), A[22:0]};
          mb_d   = {(B[30:23] != 8'h00), B[22:0]};
          ea_d   = (A[30:23] == 8'h00) ? 10'sd1 : $signed({2'b00, A[30:23]});
          eb_d   = (B[30:23] == 8'h00) ? 10'sd1 : $signed({2'b00, B[30:23]});
          spec_d = 1'b1;
          if (a_nanf || b_nanf) begin
            spec_res_d = QNAN;
          end else if (a_zero && b_zero) begin
            spec_res_d = QNAN;
          end else if (b_zero) begin
            spec_res_d = {sign_in, 8'hFF, 23'h0};
          end else if (a_zero) begin
            spec_res_d = {sign_in, 31'h0};
          end else begin
            spec_d     = 1'b0;
            spec_res_d = '0;
          end
          busy_d  = 1'b1;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (spec_q) begin
          state_d = ST_PACK;
        end else if (ma_q[MANT_W-1] && mb_q[MANT_W-1]) begin
          rem_d   = {1'b0, ma_q};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_DIV;
        end else begin
          if (!ma_q[MANT_W-1]) begin
            ma_d = {ma_q[MANT_W-2:0], 1'b0};
            ea_d = ea_q - 10'sd1;
          end
          if (!mb_q[MANT_W-1]) begin
            mb_d = {mb_q[MANT_W-2:0], 1'b0};
            eb_d = eb_q - 10'sd1;
          end
        end
      end

      ST_DIV: begin
        rem_d = {rem_next, 1'b0};
        quo_d = {quo_q[QBITS-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(QBITS - 1)) begin
          state_d = ST_PACK;
        end
      end

      ST_PACK: begin
        if (spec_q) begin
          quotient_d = spec_res_q;
        end else if (e_pack >= 10'sd255) begin
          quotient_d = {sign_q, 8'hFF, 23'h0};
        end else if (e_pack <= 10'sd0) begin
          quotient_d = {sign_q, 31'h0};
        end else begin
          quotient_d = {sign_q, e_pack[7:0], frac_pack};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Quotient = quotient_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: driver pushes expected result and due cycle,
// a negedge monitor pops and checks on every done pulse.
module tb_fp_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] quotient;

  fp_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (a_in),
    .B        (b_in),
    .busy     (busy),
    .done     (done),
    .Quotient (quotient)
  );

  typedef struct {
    logic [31:0] q;
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] last_q = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Reference: value-level division with exact integer quotient, then truncate
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output int lat);
    logic       s;
    longint     ma, mb, qi;
    int         ea, eb, na, nb, e;
    logic [22:0] frac;
    s   = a[31] ^ b[31];
    lat = 2;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) q = 32'h7FC00000;
    else if (a[30:0] == 0 && b[30:0] == 0)      q = 32'h7FC00000;
    else if (b[30:0] == 0)                      q = {s, 8'hFF, 23'h0};
    else if (a[30:0] == 0)                      q = {s, 31'h0};
    else begin
      ma = (a[30:23] != 0) ? (longint'(a[22:0]) + 64'h800000) : longint'(a[22:0]);
      mb = (b[30:23] != 0) ? (longint'(b[22:0]) + 64'h800000) : longint'(b[22:0]);
      ea = (a[30:23] != 0) ? int'(a[30:23]) : 1;
      eb = (b[30:23] != 0) ? int'(b[30:23]) : 1;
      na = 0; nb = 0;
      while (ma < 64'h800000) begin ma = ma * 2; ea = ea - 1; na = na + 1; end
      while (mb < 64'h800000) begin mb = mb * 2; eb = eb - 1; nb = nb + 1; end
      lat = 28 + ((na > nb) ? na : nb);
      qi  = (ma * 64'd33554432) / mb;
      e   = ea - eb + 127;
      if (qi >= 64'd33554432) frac = 23'((qi / 4) % 64'h800000);
      else begin frac = 23'((qi / 2) % 64'h800000); e = e - 1; end
      if (e >= 255)    q = {s, 8'hFF, 23'h0};
      else if (e <= 0) q = {s, 31'h0};
      else             q = {s, 8'(e), frac};
    end
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt = done_cnt + 1;
      if (sb.size() == 0) begin
        checks = checks + 1; errors = errors + 1;
        $display("FAIL unexpected_done Quotient=%h", quotient);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks = checks + 1;
        if (quotient !== e.q) begin
          errors = errors + 1;
          $display("FAIL quotient A=%h B=%h got=%h exp=%h", e.a, e.b, quotient, e.q);
        end
        checks = checks + 1;
        if (cyc != e.due) begin
          errors = errors + 1;
          $display("FAIL latency A=%h B=%h got_cycle=%0d exp_cycle=%0d", e.a, e.b, cyc, e.due);
        end
        checks = checks + 1;
        if (busy !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL busy_in_done got=%b exp=0", busy);
        end
        last_q = e.q;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks = checks + 1;
    if (got !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp_v);
    end
  endtask

  // Called at a negedge with the DUT idle; start is accepted at the next posedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    model(a, b, e.q, lat);
    e.a = a; e.b = b;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL timeout pending=%0d", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    wait_drain();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int          m;
    v = $urandom;
    m = $urandom_range(0, 9);
    if (m == 0)      v[30:23] = 8'h00;
    else if (m == 1) v[30:0] = 31'h0;
    else if (m == 2) v[30:23] = 8'hFF;
    else if (m == 3) v[30:23] = 8'(($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01);
    else if (m < 9)  v[30:23] = 8'($urandom_range(60, 190));
    return v;
  endfunction

  initial begin
    int n;
    int dc;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_quotient", quotient, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);

    run(32'h40C00000, 32'h40000000);
    run(32'h3F800000, 32'h40400000);
    run(32'hC0000000, 32'h3F000000);
    run(32'hBF800000, 32'h00000000);
    run(32'h00000000, 32'h00000000);
    run(32'h00000000, 32'h40000000);
    run(32'h7F800000, 32'h3F800000);
    run(32'h7F000000, 32'h3F000000);
    run(32'h00800000, 32'h40000000);
    run(32'h00400000, 32'h00800000);
    check("last_result_denorm", last_q, 32'h3F000000);

    // start pulsed mid-division must be ignored
    issue(32'h41200000, 32'h40800000);
    repeat (10) @(negedge clk);
    check("busy_mid_div", 32'(busy), 32'h1);
    check("quotient_held", quotient, last_q);
    a_in = 32'h3F800000; b_in = 32'h3F800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    check("ignored_start_result", last_q, 32'h40200000);

    // reset during DIV aborts without a done pulse
    issue(32'h40C00000, 32'h40000000);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_quotient", quotient, 32'h0);
    sb.delete();
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(dc));
    last_q = 32'h0;

    // back-to-back: next start driven in the done cycle
    issue(32'h40C00000, 32'h40000000);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    issue(32'h3F800000, 32'h40400000);
    wait_drain();

    // randomized, with random back-to-back chaining
    for (int i = 0; i < 60; i++) begin
      issue(rand_operand(), rand_operand());
      if ($urandom_range(0, 2) == 0) begin
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
      end else begin
        wait_drain();
      end
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
